// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC ownership, credit-limited pipelined imem requests,
// in-order response queue toward decode, redirect squashing and ebreak halt.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            halted_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  localparam logic [0:0] S_FETCH  = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_occ;
  logic [AW-1:0]   r_q_wr;
  logic [AW-1:0]   r_q_rd;
  logic [AW-1:0]   r_tag_wr;
  logic [AW-1:0]   r_tag_rd;

  logic [31:0]     r_q_data [DEPTH];
  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic            r_q_err  [DEPTH];
  logic [XLEN-1:0] r_tag_pc [DEPTH];

  logic            w_credit;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_rsp_discard;
  logic [CW-1:0]   w_out_nxt;
  logic            w_unused;

  // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
  assign w_credit = (SW'(r_occ) + SW'(r_outstanding)) < SW'(DEPTH);

  assign imem_req_valid_o = !rst_i && (r_state == S_FETCH) && !redirect_i && w_credit;
  assign imem_req_addr_o  = r_fetch_pc;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

  assign inst_valid_o = (r_occ != '0);
  assign inst_o       = inst_valid_o ? r_q_data[r_q_rd] : 32'd0;
  assign inst_pc_o    = inst_valid_o ? r_q_pc[r_q_rd]   : '0;
  assign inst_err_o   = inst_valid_o ? r_q_err[r_q_rd]  : 1'b0;
  assign halted_o     = (r_state == S_HALTED);

  // A response in a redirect cycle is stale by definition and never enters the queue.
  assign w_push        = imem_rsp_valid_i && (r_drop == '0) && !redirect_i;
  assign w_rsp_discard = imem_rsp_valid_i && (r_drop != '0);
  assign w_pop         = inst_valid_o && inst_ready_i && !redirect_i;
  assign w_out_nxt     = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid_i);

  assign w_unused = ^redirect_pc_i[1:0];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a redirect always resumes fetching, even alongside halt
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i) begin
      w_state_nxt = S_FETCH;
    end else if (halt_i) begin
      w_state_nxt = S_HALTED;
    end
  end

  // PC, credit counters and queue/tag pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_occ         <= '0;
      r_q_wr        <= '0;
      r_q_rd        <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_req_fire) begin
        r_tag_wr <= r_tag_wr + AW'(1);
      end
      if (imem_rsp_valid_i) begin
        r_tag_rd <= r_tag_rd + AW'(1);
      end
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
        r_drop     <= w_out_nxt;
        r_occ      <= '0;
        r_q_wr     <= '0;
        r_q_rd     <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_rsp_discard) begin
          r_drop <= r_drop - CW'(1);
        end
        r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        if (w_push) begin
          r_q_wr <= r_q_wr + AW'(1);
        end
        if (w_pop) begin
          r_q_rd <= r_q_rd + AW'(1);
        end
      end
    end
  end

  // Storage arrays; contents are only observed through valid occupancy
  always_ff @(posedge clk_i) begin
    if (w_req_fire) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_q_data[r_q_wr] <= imem_rsp_data_i;
      r_q_pc[r_q_wr]   <= r_tag_pc[r_tag_rd];
      r_q_err[r_q_wr]  <= imem_rsp_err_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side in-order memory with fixed latency,
// hand-computed PC/data/flag expectations per scenario.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_err_o       (inst_err_o),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_i           (halt_i),
    .halted_o         (halted_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc, lat, n_req, rsp_cnt, err_idx;
  int    checks = 0;
  int    failures = 0;

  logic        obs_req_valid, obs_inst_valid, obs_err, obs_halted;
  logic [31:0] obs_req_addr, obs_inst, obs_pc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory response, settle, sample, book-keep, advance.
  task automatic tick();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    imem_rsp_err_i   = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mq[0].addr ^ 32'hAAAA;
      imem_rsp_err_i   = (rsp_cnt == err_idx);
    end
    #1;
    obs_req_valid  = imem_req_valid_o;
    obs_req_addr   = imem_req_addr_o;
    obs_inst_valid = inst_valid_o;
    obs_inst       = inst_o;
    obs_pc         = inst_pc_o;
    obs_err        = inst_err_o;
    obs_halted     = halted_o;
    if (obs_req_valid && imem_req_ready_i) begin
      mq.push_back('{addr: obs_req_addr, due: cyc + lat});
      n_req++;
    end
    if (imem_rsp_valid_i) begin
      void'(mq.pop_front());
      rsp_cnt++;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    halt_i        = 1'b0;
    mq.delete();
    tick();
    tick();
    chk_eq("rst_req_valid", 32'(obs_req_valid), 32'd0);
    chk_eq("rst_req_addr", obs_req_addr, 32'h8000_0000);
    chk_eq("rst_inst_valid", 32'(obs_inst_valid), 32'd0);
    chk_eq("rst_halted", 32'(obs_halted), 32'd0);
    chk_eq("rst_inst", obs_inst, 32'd0);
    chk_eq("rst_inst_pc", obs_pc, 32'd0);
    chk_eq("rst_inst_err", 32'(obs_err), 32'd0);
    rst_i   = 1'b0;
    cyc     = 0;
    n_req   = 0;
    rsp_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    int          n_del;
    int          n_vis;

    rst_i            = 1'b1;
    imem_req_ready_i = 1'b0;
    inst_ready_i     = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    imem_rsp_err_i   = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'd0;
    halt_i           = 1'b0;
    cyc = 0; lat = 1; n_req = 0; rsp_cnt = 0; err_idx = -1;
    @(posedge clk_i);
    #1;

    // Streaming with 1-cycle memory
    do_reset();
    imem_req_ready_i = 1'b1;
    inst_ready_i     = 1'b1;
    lat              = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        chk_eq("s1_first_valid", 32'(obs_req_valid), 32'd1);
        chk_eq("s1_first_addr", obs_req_addr, 32'h8000_0000);
      end
      if (c >= 2) begin
        exp_pc = 32'h8000_0000 + 32'(4 * (c - 2));
        chk_eq("s1_valid", 32'(obs_inst_valid), 32'd1);
        chk_eq("s1_pc", obs_pc, exp_pc);
        chk_eq("s1_inst", obs_inst, exp_pc ^ 32'hAAAA);
      end
    end

    // Backpressure: credit stops at DEPTH, then one request per pop
    do_reset();
    inst_ready_i = 1'b0;
    repeat (8) tick();
    chk_eq("s2_req_count", 32'(n_req), 32'd4);
    chk_eq("s2_req_valid_full", 32'(obs_req_valid), 32'd0);
    chk_eq("s2_head_valid", 32'(obs_inst_valid), 32'd1);
    chk_eq("s2_head_pc", obs_pc, 32'h8000_0000);
    inst_ready_i = 1'b1;
    exp_pc = 32'h8000_0000;
    n_del  = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (obs_inst_valid) begin
        chk_eq("s2_pc", obs_pc, exp_pc);
        chk_eq("s2_inst", obs_inst, exp_pc ^ 32'hAAAA);
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
    end
    chk_eq("s2_delivered", 32'(n_del), 32'd12);
    chk_eq("s2_req_total", 32'(n_req), 32'd15);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    tick();
    tick();
    imem_req_ready_i = 1'b0;
    redirect_i       = 1'b1;
    redirect_pc_i    = 32'h8000_0103;
    tick();
    chk_eq("s3_redir_req_valid", 32'(obs_req_valid), 32'd0);
    redirect_i       = 1'b0;
    imem_req_ready_i = 1'b1;
    tick();
    chk_eq("s3_new_req_valid", 32'(obs_req_valid), 32'd1);
    chk_eq("s3_new_req_addr", obs_req_addr, 32'h8000_0100);
    n_vis = obs_inst_valid ? 1 : 0;
    repeat (3) begin
      tick();
      if (obs_inst_valid) n_vis++;
    end
    chk_eq("s3_stale_visible", 32'(n_vis), 32'd0);
    tick();
    chk_eq("s3_first_valid", 32'(obs_inst_valid), 32'd1);
    chk_eq("s3_first_pc", obs_pc, 32'h8000_0100);
    chk_eq("s3_first_inst", obs_inst, 32'h8000_0100 ^ 32'hAAAA);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat = 1;
    repeat (5) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0300;
    tick();
    chk_eq("s4_pop_in_redir", 32'(obs_inst_valid), 32'd1);
    chk_eq("s4_redir_req_valid", 32'(obs_req_valid), 32'd0);
    redirect_i = 1'b0;
    tick();
    chk_eq("s4_queue_empty", 32'(obs_inst_valid), 32'd0);
    chk_eq("s4_new_req_addr", obs_req_addr, 32'h8000_0300);
    tick();
    chk_eq("s4_still_empty", 32'(obs_inst_valid), 32'd0);
    tick();
    chk_eq("s4_first_valid", 32'(obs_inst_valid), 32'd1);
    chk_eq("s4_first_pc", obs_pc, 32'h8000_0300);

    // Halt, drain, resume by redirect
    do_reset();
    inst_ready_i = 1'b0;
    tick();
    tick();
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    tick();
    chk_eq("s5_halted", 32'(obs_halted), 32'd1);
    chk_eq("s5_halt_req_valid", 32'(obs_req_valid), 32'd0);
    inst_ready_i = 1'b1;
    exp_pc = 32'h8000_0000;
    n_del  = 0;
    repeat (6) begin
      tick();
      if (obs_inst_valid) begin
        chk_eq("s5_drain_pc", obs_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
    end
    chk_eq("s5_drained", 32'(n_del), 32'd3);
    chk_eq("s5_req_total", 32'(n_req), 32'd3);
    chk_eq("s5_still_halted", 32'(obs_halted), 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    tick();
    redirect_i = 1'b0;
    tick();
    chk_eq("s5_resumed", 32'(obs_halted), 32'd0);
    chk_eq("s5_resume_valid", 32'(obs_req_valid), 32'd1);
    chk_eq("s5_resume_addr", obs_req_addr, 32'h8000_0200);
    tick();
    tick();
    chk_eq("s5_resume_pc", obs_pc, 32'h8000_0200);

    // Error on second response, then wrap at the top of the address space
    do_reset();
    err_idx = 1;
    tick();
    tick();
    tick();
    chk_eq("s6_pc0", obs_pc, 32'h8000_0000);
    chk_eq("s6_err0", 32'(obs_err), 32'd0);
    tick();
    chk_eq("s6_pc1", obs_pc, 32'h8000_0004);
    chk_eq("s6_err1", 32'(obs_err), 32'd1);
    tick();
    chk_eq("s6_pc2", obs_pc, 32'h8000_0008);
    chk_eq("s6_err2", 32'(obs_err), 32'd0);
    err_idx       = -1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    tick();
    chk_eq("s6_top_addr", obs_req_addr, 32'hFFFF_FFFC);
    tick();
    chk_eq("s6_wrap_valid", 32'(obs_req_valid), 32'd1);
    chk_eq("s6_wrap_addr", obs_req_addr, 32'h0000_0000);
    tick();
    chk_eq("s6_top_pc", obs_pc, 32'hFFFF_FFFC);
    chk_eq("s6_top_err", 32'(obs_err), 32'd0);
    tick();
    chk_eq("s6_wrap_pc", obs_pc, 32'h0000_0000);

    // Halt and redirect together: redirect wins
    halt_i        = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0400;
    tick();
    halt_i     = 1'b0;
    redirect_i = 1'b0;
    tick();
    chk_eq("s7_not_halted", 32'(obs_halted), 32'd0);
    chk_eq("s7_req_valid", 32'(obs_req_valid), 32'd1);
    chk_eq("s7_req_addr", obs_req_addr, 32'h8000_0400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
